// File: rtl/wshb_arb_pkg.sv
// Shared types and helpers for the N-master Wishbone arbiter.
package wshb_arb_pkg;

  typedef enum logic {IDLE, OWNED} arb_state_t;
  typedef enum {PRIO_RR, PRIO_FIXED} prio_mode_t;

  localparam int MAX_MST = 8;

  function automatic int idxW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Grant vectors are zero-extended to MAX_MST bits before conversion.
  function automatic int onehotToIdx(input logic [MAX_MST-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_MST; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/wshb_rr_pick.sv
// Combinational winner selection: rotating priority after 'last', or fixed
// priority with index 0 highest.
module wshb_rr_pick #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic             fixedPrio,
  output logic [IDX_W-1:0] winner,
  output logic             valid
);

  logic [IDX_W-1:0] cand [N];
  logic [N-1:0]     candReq;

  // cand[0] is the highest-priority index for the current mode.
  for (genvar gi = 0; gi < N; gi++) begin : gCand
    assign cand[gi]    = fixedPrio ? IDX_W'(gi) : IDX_W'((int'(last) + gi + 1) % N);
    assign candReq[gi] = req[cand[gi]];
  end

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (candReq[i]) begin
        winner = cand[i];
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wshb_arbiter_n.sv
// N-master to 1-slave Wishbone B4 arbiter with registered grant held for a whole cycle.
// Optional owner watchdog enabled by defining WSHB_ARB_TIMEOUT_EN.
module wshb_arbiter_n
  import wshb_arb_pkg::*;
#(
  parameter int N_MST     = 2,
  parameter int ADR_W     = 32,
  parameter int DAT_W     = 32,
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255,
  localparam int SEL_W    = DAT_W / 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_MST-1:0]       m_cyc,
  input  logic [N_MST-1:0]       m_stb,
  input  logic [N_MST-1:0]       m_we,
  input  logic [N_MST*ADR_W-1:0] m_adr,
  input  logic [N_MST*DAT_W-1:0] m_dat_ms,
  input  logic [N_MST*SEL_W-1:0] m_sel,
  input  logic [N_MST*3-1:0]     m_cti,
  input  logic [N_MST*2-1:0]     m_bte,
  output logic [N_MST-1:0]       m_ack,
  output logic [N_MST-1:0]       m_err,
  output logic [DAT_W-1:0]       m_dat_sm,
  output logic [N_MST-1:0]       m_gnt,
  output logic                   s_cyc,
  output logic                   s_stb,
  output logic                   s_we,
  output logic [ADR_W-1:0]       s_adr,
  output logic [DAT_W-1:0]       s_dat_ms,
  output logic [SEL_W-1:0]       s_sel,
  output logic [2:0]             s_cti,
  output logic [1:0]             s_bte,
  input  logic [DAT_W-1:0]       s_dat_sm,
  input  logic                   s_ack,
  input  logic                   s_err
);

  localparam int IDX_W = idxW(N_MST);
  localparam prio_mode_t MODE = (PRIO_MODE == 1) ? PRIO_FIXED : PRIO_RR;

  arb_state_t       stateReg, stateNext;
  logic [N_MST-1:0] gntReg, gntNext;
  logic [IDX_W-1:0] lastReg, lastNext, ownerIdx, winIdx;
  logic             winValid, ownerCyc, timeoutHit, releaseNow;

  wshb_rr_pick #(.N(N_MST), .IDX_W(IDX_W)) uPick (
    .req      (m_cyc),
    .last     (lastReg),
    .fixedPrio(MODE == PRIO_FIXED),
    .winner   (winIdx),
    .valid    (winValid)
  );

  assign ownerIdx   = IDX_W'(onehotToIdx(MAX_MST'(gntReg)));
  assign ownerCyc   = |(m_cyc & gntReg);
  assign releaseNow = (stateReg == OWNED) && (!ownerCyc || timeoutHit);

`ifdef WSHB_ARB_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

  logic [WD_W-1:0] wdogReg;
  logic            stalled;

  // Counts stalled strobe cycles; the TIMEOUT-th one errors the owner out.
  assign stalled    = (stateReg == OWNED) && s_stb && !s_ack;
  assign timeoutHit = stalled && (wdogReg == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || stateReg != OWNED || releaseNow || s_ack) begin
      wdogReg <= '0;
    end else if (stalled) begin
      wdogReg <= wdogReg + WD_W'(1);
    end
  end
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT != 0);
  assign timeoutHit    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      gntReg   <= '0;
      lastReg  <= IDX_W'(N_MST - 1);
    end else begin
      stateReg <= stateNext;
      gntReg   <= gntNext;
      lastReg  <= lastNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    gntNext   = gntReg;
    lastNext  = lastReg;
    case (stateReg)
      IDLE: begin
        if (winValid) begin
          stateNext       = OWNED;
          gntNext         = '0;
          gntNext[winIdx] = 1'b1;
        end
      end
      OWNED: begin
        if (releaseNow) begin
          stateNext = IDLE;
          gntNext   = '0;
          lastNext  = ownerIdx;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // The owner dropping cyc releases the slave port in the same cycle.
  always_comb begin
    s_cyc = 1'b0;
    s_stb = 1'b0;
    s_we  = 1'b0;
    if (stateReg == OWNED) begin
      s_cyc = ownerCyc;
      s_stb = ownerCyc & m_stb[ownerIdx];
      s_we  = m_we[ownerIdx];
    end
  end

  assign s_adr    = m_adr[ownerIdx*ADR_W +: ADR_W];
  assign s_dat_ms = m_dat_ms[ownerIdx*DAT_W +: DAT_W];
  assign s_sel    = m_sel[ownerIdx*SEL_W +: SEL_W];
  assign s_cti    = m_cti[ownerIdx*3 +: 3];
  assign s_bte    = m_bte[ownerIdx*2 +: 2];
  assign m_dat_sm = s_dat_sm;
  assign m_gnt    = gntReg;

  for (genvar gi = 0; gi < N_MST; gi++) begin : gRoute
    assign m_ack[gi] = s_ack & gntReg[gi];
    assign m_err[gi] = (s_err | timeoutHit) & gntReg[gi];
  end

endmodule

// File: tb/tb_wshb_arbiter_n.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus stream.
// Watchdog steps run only when WSHB_ARB_TIMEOUT_EN is defined.
module tb_wshb_arbiter_n;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N-1:0]    m_cyc, m_stb, m_we;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat_ms;
  logic [N*SW-1:0] m_sel;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   s_dat_sm;
  logic            s_ack, s_err;

  logic [N-1:0]  rAck, rErr, rGnt, fAck, fErr, fGnt;
  logic [DW-1:0] rDatSm, fDatSm, rsDat, fsDat;
  logic          rsCyc, rsStb, rsWe, fsCyc, fsStb, fsWe;
  logic [AW-1:0] rsAdr, fsAdr;
  logic [SW-1:0] rsSel, fsSel;
  logic [2:0]    rsCti, fsCti;
  logic [1:0]    rsBte, fsBte;

  int total = 0;
  int bad   = 0;

  wshb_arbiter_n #(.N_MST(N), .ADR_W(AW), .DAT_W(DW), .PRIO_MODE(0), .TIMEOUT(4)) uRr (
    .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_ack(rAck),
    .m_err(rErr), .m_dat_sm(rDatSm), .m_gnt(rGnt), .s_cyc(rsCyc), .s_stb(rsStb),
    .s_we(rsWe), .s_adr(rsAdr), .s_dat_ms(rsDat), .s_sel(rsSel), .s_cti(rsCti),
    .s_bte(rsBte), .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err)
  );

  wshb_arbiter_n #(.N_MST(N), .ADR_W(AW), .DAT_W(DW), .PRIO_MODE(1), .TIMEOUT(4)) uFx (
    .clk(clk), .rst_n(rst_n), .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
    .m_dat_ms(m_dat_ms), .m_sel(m_sel), .m_cti(m_cti), .m_bte(m_bte), .m_ack(fAck),
    .m_err(fErr), .m_dat_sm(fDatSm), .m_gnt(fGnt), .s_cyc(fsCyc), .s_stb(fsStb),
    .s_we(fsWe), .s_adr(fsAdr), .s_dat_ms(fsDat), .s_sel(fsSel), .s_cti(fsCti),
    .s_bte(fsBte), .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    int ord [4] = '{0, 1, 2, 0};
    logic [N-1:0] oh;

    rst_n = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat_ms = '0;
    m_sel = '0; m_cti = '0; m_bte = '0; s_dat_sm = '0; s_ack = 1'b1; s_err = 1'b0;

    // Reset state, with the slave acking to prove nothing is forwarded.
    nxt(); nxt(); smp();
    chk("rst_gnt", rGnt, 3'b000);
    chk("rst_scyc", rsCyc, 1'b0);
    chk("rst_ack", rAck, 3'b000);
    chk("rst_fgnt", fGnt, 3'b000);

    // Single master: one clock from request to s_cyc.
    nxt(); rst_n = 1'b1; s_ack = 1'b0; m_cyc = 3'b001; m_stb = 3'b001;
    smp(); chk("single_lat0", rsCyc, 1'b0);
    nxt(); smp();
    chk("single_gnt", rGnt, 3'b001);
    chk("single_scyc", rsCyc, 1'b1);
    chk("single_noack", rAck, 3'b000);
    s_ack = 1'b1; #1;
    chk("single_ack", rAck, 3'b001);
    nxt(); s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    smp(); chk("single_rel_scyc", rsCyc, 1'b0);
    nxt(); smp(); chk("single_idle_gnt", rGnt, 3'b000);

    // Round-robin fairness: four 4-beat cycles, all masters requesting.
    rst_n = 1'b0;
    nxt(); nxt(); rst_n = 1'b1; m_cyc = 3'b111; m_stb = 3'b111; s_ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      oh = N'(1 << ord[k]);
      smp();
      chk("rr_idle_gnt", rGnt, 3'b000);
      chk("rr_idle_ack", rAck, 3'b000);
      nxt(); smp();
      chk("rr_gnt", rGnt, oh);
      for (int b = 0; b < 4; b++) begin
        if (b > 0) begin nxt(); smp(); end
        chk("rr_beat_ack", rAck, oh);
      end
      nxt(); m_cyc = 3'b111 & ~oh;
      smp(); chk("rr_rel_scyc", rsCyc, 1'b0);
      nxt(); m_cyc = (k == 3) ? 3'b000 : 3'b111;
    end
    s_ack = 1'b0; m_stb = '0;

    // Fixed priority: 1 beats 2, 2 follows, late 0 waits for 2 to finish.
    rst_n = 1'b0;
    nxt(); nxt(); rst_n = 1'b1; m_cyc = 3'b110;
    smp(); chk("fx_idle", fGnt, 3'b000);
    nxt(); smp();
    chk("fx_gnt1", fGnt, 3'b010);
    chk("fx_scyc1", fsCyc, 1'b1);
    nxt(); m_cyc = 3'b100;
    smp(); chk("fx_rel1_scyc", fsCyc, 1'b0);
    nxt(); smp(); chk("fx_gap", fGnt, 3'b000);
    nxt(); smp(); chk("fx_gnt2", fGnt, 3'b100);
    nxt(); m_cyc = 3'b101;
    smp(); chk("fx_wait0_a", fGnt, 3'b100);
    nxt(); smp(); chk("fx_wait0_b", fGnt, 3'b100);
    nxt(); m_cyc = 3'b001;
    smp(); chk("fx_rel2_scyc", fsCyc, 1'b0);
    nxt(); smp(); chk("fx_gap2", fGnt, 3'b000);
    nxt(); smp(); chk("fx_gnt0", fGnt, 3'b001);
    nxt(); m_cyc = '0;
    nxt();

    // Reset during beat 2 drops ownership; master 0 is then favoured over 1.
    m_cyc = 3'b010; m_stb = 3'b010; s_ack = 1'b1;
    smp(); chk("mr_idle", rGnt, 3'b000);
    nxt(); smp();
    chk("mr_gnt", rGnt, 3'b010);
    chk("mr_beat1", rAck, 3'b010);
    nxt(); smp();
    chk("mr_beat2", rAck, 3'b010);
    rst_n = 1'b0;
    nxt(); rst_n = 1'b1; m_cyc = 3'b011; m_stb = 3'b011;
    smp();
    chk("mr_gnt_drop", rGnt, 3'b000);
    chk("mr_scyc_drop", rsCyc, 1'b0);
    chk("mr_ack_drop", rAck, 3'b000);
    nxt(); smp(); chk("mr_fav0", rGnt, 3'b001);
    nxt(); m_cyc = '0; m_stb = '0; s_ack = 1'b0;
    nxt(); smp(); chk("mr_idle2", rGnt, 3'b000);

    // Data path: master 1 write, read data broadcast.
    nxt();
    m_adr    = {32'h0000_0300, 32'h0000_0100, 32'h0000_0AAA};
    m_dat_ms = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111};
    m_sel    = {4'h3, 4'hF, 4'h1};
    m_cti    = {3'b001, 3'b111, 3'b010};
    m_bte    = {2'b11, 2'b01, 2'b10};
    m_we     = 3'b010; m_cyc = 3'b010; m_stb = 3'b010; s_dat_sm = 32'h1234_5678;
    nxt(); smp();
    chk("dp_gnt", rGnt, 3'b010);
    chk("dp_stb", rsStb, 1'b1);
    chk("dp_we", rsWe, 1'b1);
    chk("dp_adr", rsAdr, 32'h0000_0100);
    chk("dp_dat", rsDat, 32'hDEAD_BEEF);
    chk("dp_sel", rsSel, 4'hF);
    chk("dp_cti", rsCti, 3'b111);
    chk("dp_bte", rsBte, 2'b01);
    chk("dp_rdat", rDatSm, 32'h1234_5678);
    s_ack = 1'b1; s_err = 1'b1; #1;
    chk("dp_ack", rAck, 3'b010);
    chk("dp_err", rErr, 3'b010);
    nxt(); m_cyc = '0; m_stb = '0; m_we = '0; s_ack = 1'b0; s_err = 1'b0;
    nxt();

`ifdef WSHB_ARB_TIMEOUT_EN
    // Watchdog: slave never acks; owner 0 errored out on the 4th stalled cycle.
    m_cyc = 3'b011; m_stb = 3'b011;
    nxt(); smp();
    chk("to_gnt0", rGnt, 3'b001);
    for (int c = 1; c <= 3; c++) begin
      chk("to_noerr", rErr, 3'b000);
      nxt(); smp();
    end
    chk("to_err", rErr, 3'b001);
    nxt(); smp();
    chk("to_scyc", rsCyc, 1'b0);
    chk("to_gnt_drop", rGnt, 3'b000);
    nxt(); smp();
    chk("to_next", rGnt, 3'b010);
    m_cyc = '0; m_stb = '0;
    nxt(); nxt();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
